// File: rtl/matmul_feed_ctrl.sv
// Operand staging and skewed feed sequencer for a 3x3 systolic MAC array.
// Holds A/B operand files, clears the accumulators, streams diagonally skewed operands, then waits out the array latency.
module matmul_feed_ctrl #(
   parameter int unsigned MAC_LAT = 1,
   parameter int unsigned N       = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   input  logic              ld_sel,
   input  logic [3:0]        ld_idx,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              acc_clr,
   output logic              feed_valid,
   output logic [8*N-1:0]    a_feed,
   output logic [8*N-1:0]    b_feed
);

   localparam int unsigned DW        = 8;
   localparam int unsigned NUM_EL    = N * N;
   localparam int unsigned FEED_LEN  = 2 * N - 1;
   localparam int unsigned DRAIN_LEN = 2 + MAC_LAT;
   localparam int unsigned MAX_CNT   = (DRAIN_LEN > FEED_LEN) ? DRAIN_LEN : FEED_LEN;
   localparam int unsigned CNT_W     = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [DW-1:0]    a_mem [NUM_EL];
   logic [DW-1:0]    b_mem [NUM_EL];
   logic             wr_en;

   // State register and per-state timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   assign wr_en = ld_valid && ld_ready && (ld_idx <= 4'(NUM_EL - 1));

   // Operand files; contents persist across runs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NUM_EL); k++) begin
            a_mem[k] <= '0;
            b_mem[k] <= '0;
         end
      end else if (wr_en) begin
         if (ld_sel) b_mem[ld_idx] <= ld_data;
         else        a_mem[ld_idx] <= ld_data;
      end
   end

   // Next state, timer and output decode from registered state/counter
   always_comb begin
      state_d    = state;
      ld_ready   = (state == IDLE);
      busy       = (state != IDLE);
      done       = (state == DONE);
      acc_clr    = (state == CLEAR);
      feed_valid = (state == FEED);
      a_feed     = '0;
      b_feed     = '0;

      unique case (state)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   state_d = FEED;
         FEED:    if (cnt == CNT_W'(FEED_LEN - 1)) state_d = DRAIN;
         DRAIN:   if (cnt == CNT_W'(DRAIN_LEN - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cnt_d = ((state_d != state) || (state == IDLE)) ? '0 : cnt + CNT_W'(1);

      // Row i / column i see element (t-i) of its wavefront, zero outside the band
      if (state == FEED) begin
         for (int i = 0; i < int'(N); i++) begin
            if ((int'(cnt) >= i) && (int'(cnt) - i < int'(N))) begin
               a_feed[i*DW +: DW] = a_mem[4'(i * int'(N) + int'(cnt) - i)];
               b_feed[i*DW +: DW] = b_mem[4'((int'(cnt) - i) * int'(N) + i)];
            end
         end
      end
   end

endmodule

// File: tb/tb_matmul_feed_ctrl.sv
// Scoreboard bench for matmul_feed_ctrl: a matrix-level model predicts every clear/feed/done event and its cycle.
module tb_matmul_feed_ctrl;

   localparam int MAC_LAT = 1;
   localparam int DL      = 2 + MAC_LAT;
   localparam logic [2:0] K_CLR  = 3'b100;
   localparam logic [2:0] K_FEED = 3'b010;
   localparam logic [2:0] K_DONE = 3'b001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_valid = 1'b0;
   logic        ld_sel = 1'b0;
   logic [3:0]  ld_idx = '0;
   logic [7:0]  ld_data = '0;
   logic        ld_ready;
   logic        start = 1'b0;
   logic        busy, done, acc_clr, feed_valid;
   logic [23:0] a_feed, b_feed;

   matmul_feed_ctrl #(.MAC_LAT(MAC_LAT), .N(3)) dut (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_idx(ld_idx),
      .ld_data(ld_data), .ld_ready(ld_ready), .start(start), .busy(busy), .done(done),
      .acc_clr(acc_clr), .feed_valid(feed_valid), .a_feed(a_feed), .b_feed(b_feed)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  kind;
      int unsigned cyc;
      logic [23:0] a;
      logic [23:0] b;
   } ev_t;
   ev_t evq[$];

   logic [7:0] ma [3][3];
   logic [7:0] mb [3][3];
   int unsigned run_lo = 1, run_hi = 0;
   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Matrix-level view: at step t, row i presents A[i][t-i], column j presents B[t-j][j]
   function automatic logic [23:0] exp_a(input int t);
      logic [23:0] r = '0;
      for (int i = 0; i < 3; i++)
         if (t - i >= 0 && t - i <= 2) r[i*8 +: 8] = ma[i][t-i];
      return r;
   endfunction

   function automatic logic [23:0] exp_b(input int t);
      logic [23:0] r = '0;
      for (int j = 0; j < 3; j++)
         if (t - j >= 0 && t - j <= 2) r[j*8 +: 8] = mb[t-j][j];
      return r;
   endfunction

   task automatic model_write(input logic s, input logic [3:0] idx, input logic [7:0] d);
      if (idx <= 4'd8) begin
         if (s) mb[int'(idx)/3][int'(idx)%3] = d;
         else   ma[int'(idx)/3][int'(idx)%3] = d;
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            ma[r][c] = '0;
            mb[r][c] = '0;
         end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event
   always @(negedge clk) begin
      if (rst_n) begin
         logic [2:0] obs;
         logic       exp_busy;
         obs = {acc_clr, feed_valid, done};
         exp_busy = (cyc >= run_lo) && (cyc <= run_hi);
         chk("busy", busy, exp_busy);
         chk("ld_ready", ld_ready, !exp_busy);
         if (!feed_valid) chk("idle_feeds_zero", {a_feed, b_feed}, 48'h0);
         if (obs != 3'b000) begin
            if (evq.size() == 0) chk("spurious_event", obs, 3'b000);
            else begin
               ev_t e;
               e = evq.pop_front();
               chk("event_kind", obs, e.kind);
               chk("event_cycle", cyc, e.cyc);
               if (e.kind == K_FEED) begin
                  chk("a_feed", a_feed, e.a);
                  chk("b_feed", b_feed, e.b);
               end
            end
         end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
            ev_t e;
            e = evq.pop_front();
            chk("missed_event", obs, e.kind);
         end
      end
   end

   task automatic load(input logic s, input logic [3:0] idx, input logic [7:0] d);
      @(negedge clk);
      ld_valid = 1'b1; ld_sel = s; ld_idx = idx; ld_data = d;
      @(posedge clk);
      model_write(s, idx, d);
      #1 ld_valid = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_acc_clr", acc_clr, 1'b0);
      chk("rst_feed_valid", feed_valid, 1'b0);
      chk("rst_a_feed", a_feed, 24'h0);
      chk("rst_b_feed", b_feed, 24'h0);
      chk("rst_ld_ready", ld_ready, 1'b1);
   endtask

   task automatic run_op(input bit with_ld, input logic ls, input logic [3:0] li,
                         input logic [7:0] ld, input bit disturb, input bit abort);
      int unsigned e0;
      int k;
      @(negedge clk);
      start = 1'b1;
      if (with_ld) begin
         ld_valid = 1'b1; ld_sel = ls; ld_idx = li; ld_data = ld;
      end
      @(posedge clk);
      if (with_ld) model_write(ls, li, ld);
      #1;
      start = 1'b0;
      ld_valid = 1'b0;
      e0 = cyc;
      run_lo = e0;
      run_hi = e0 + 6 + DL;
      evq.push_back('{K_CLR, e0, 24'h0, 24'h0});
      for (int t = 0; t < 5; t++)
         evq.push_back('{K_FEED, e0 + 1 + t, exp_a(t), exp_b(t)});
      evq.push_back('{K_DONE, e0 + 6 + DL, 24'h0, 24'h0});

      if (disturb) begin
         repeat (3) @(negedge clk);
         chk("ld_ready_during_feed", ld_ready, 1'b0);
         start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_idx = 4'd4; ld_data = 8'h44;
         @(posedge clk);
         #1 start = 1'b0; ld_valid = 1'b0;
      end

      if (abort) begin
         repeat (7) @(negedge clk);
         #2 rst_n = 1'b0;
         #1 check_reset_outputs();
         evq.delete();
         model_clear();
         run_lo = 1; run_hi = 0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (5) @(negedge clk);
         chk("idle_after_abort", busy, 1'b0);
         return;
      end

      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < 60);
      chk("run_end_cycle", cyc, e0 + 7 + DL);
      chk("queue_drained", evq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      #1 check_reset_outputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Uniform operands
      for (int k = 0; k < 9; k++) begin
         load(1'b0, 4'(k), 8'h20);
         load(1'b1, 4'(k), 8'h30);
      end
      run_op(0, 0, 0, 0, 0, 0);

      // Distinct elements expose the skew pattern
      for (int k = 0; k < 9; k++) begin
         load(1'b0, 4'(k), 8'(8'h10 + k));
         load(1'b1, 4'(k), 8'(8'h40 + k));
      end
      run_op(0, 0, 0, 0, 0, 0);

      // Write attempt and second start while busy: dropped; next run shows old A[4]
      run_op(0, 0, 0, 0, 1, 0);
      run_op(0, 0, 0, 0, 0, 0);

      // Out-of-range indices are dropped
      load(1'b0, 4'd9, 8'hEE);
      load(1'b1, 4'd15, 8'hDD);
      run_op(0, 0, 0, 0, 0, 0);

      // Load in the same cycle as start is used by that run
      run_op(1, 1'b0, 4'd4, 8'h5A, 0, 0);
      run_op(1, 1'b1, 4'd8, 8'hC3, 0, 0);

      // Randomized operands, including stray illegal writes
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 9; k++) begin
            load(1'b0, 4'(k), 8'($urandom));
            load(1'b1, 4'(k), 8'($urandom));
         end
         for (int k = 0; k < 4; k++)
            load(1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom));
         run_op(0, 0, 0, 0, 0, 0);
      end

      // Reset mid-run, then operands must read back as zero
      run_op(0, 0, 0, 0, 0, 1);
      run_op(0, 0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("final_queue_empty", evq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
